// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: 48/136-bit frames, framing check, optional CRC7, start-bit timeout.
// Define SD_RESP_CRC_EN to build the CRC7 checker; otherwise crc_err is tied 0.
module sd_cmd_resp_rx #(
    parameter int unsigned TIMEOUT_CLKS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sd_clk_rise,
    input  logic         cmd_in,
    input  logic         start,
    input  logic         long_resp,
    input  logic         check_crc,
    input  logic         abort,
    output logic         busy,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_data,
    output logic         timeout,
    output logic         crc_err,
    output logic         frame_err
);

    localparam int unsigned ToutW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [ToutW-1:0] ToutMax = ToutW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {StIdle, StWait, StRecv, StDone} state_e;

    state_e             state_q, state_d;
    logic               long_q, long_d;
    logic [7:0]         bit_cnt_q, bit_cnt_d;
    logic [ToutW-1:0]   tout_cnt_q, tout_cnt_d;
    logic [126:0]       sr_q, sr_d;
    logic               tx_err_q, tx_err_d;
    logic [127:0]       resp_data_q, resp_data_d;
    logic               timeout_q, timeout_d;
    logic               crc_err_q, crc_err_d;
    logic               frame_err_q, frame_err_d;

    logic               cfg_load;
    logic               crc_en;
    logic               crc_din;
    logic               crc_bad;
    logic               crc_window;
    logic [7:0]         last_bit;

    // Long frames: CRC covers the CID/CSD body only, skipping the reserved 1s after the start.
    assign crc_window = long_q ? (bit_cnt_q >= 8'd8 && bit_cnt_q <= 8'd127)
                               : (bit_cnt_q <= 8'd39);
    assign last_bit   = long_q ? 8'd135 : 8'd47;

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        bit_cnt_d   = bit_cnt_q;
        tout_cnt_d  = tout_cnt_q;
        sr_d        = sr_q;
        tx_err_d    = tx_err_q;
        resp_data_d = resp_data_q;
        timeout_d   = timeout_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        cfg_load    = 1'b0;
        crc_en      = 1'b0;
        crc_din     = cmd_in;

        if (abort) begin
            state_d     = StIdle;
            bit_cnt_d   = '0;
            tout_cnt_d  = '0;
            sr_d        = '0;
            tx_err_d    = 1'b0;
            resp_data_d = '0;
            timeout_d   = 1'b0;
            crc_err_d   = 1'b0;
            frame_err_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d     = StWait;
                        long_d      = long_resp;
                        cfg_load    = 1'b1;
                        bit_cnt_d   = '0;
                        tout_cnt_d  = '0;
                        sr_d        = '0;
                        tx_err_d    = 1'b0;
                        resp_data_d = '0;
                        timeout_d   = 1'b0;
                        crc_err_d   = 1'b0;
                        frame_err_d = 1'b0;
                    end
                end
                StWait: begin
                    if (sd_clk_rise) begin
                        if (!cmd_in) begin
                            bit_cnt_d = 8'd1;
                            crc_en    = 1'b1;
                            crc_din   = 1'b0;
                            state_d   = StRecv;
                        end else begin
                            if (tout_cnt_q != ToutMax) begin
                                tout_cnt_d = tout_cnt_q + 1'b1;
                            end
                            if (tout_cnt_d == ToutMax) begin
                                timeout_d   = 1'b1;
                                resp_data_d = '0;
                                state_d     = StDone;
                            end
                        end
                    end
                end
                StRecv: begin
                    if (sd_clk_rise) begin
                        crc_en = crc_window;
                        if (bit_cnt_q == last_bit) begin
                            // End bit is checked but never shifted, so sr_q[6:0] holds the CRC field.
                            frame_err_d = tx_err_q | ~cmd_in;
                            crc_err_d   = crc_bad;
                            resp_data_d = long_q ? {1'b0, sr_q} : {90'b0, sr_q[44:7]};
                            state_d     = StDone;
                        end else begin
                            sr_d      = {sr_q[125:0], cmd_in};
                            bit_cnt_d = bit_cnt_q + 8'd1;
                            if (bit_cnt_q == 8'd1) begin
                                tx_err_d = cmd_in;
                            end
                        end
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            long_q      <= 1'b0;
            bit_cnt_q   <= '0;
            tout_cnt_q  <= '0;
            sr_q        <= '0;
            tx_err_q    <= 1'b0;
            resp_data_q <= '0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            bit_cnt_q   <= bit_cnt_d;
            tout_cnt_q  <= tout_cnt_d;
            sr_q        <= sr_d;
            tx_err_q    <= tx_err_d;
            resp_data_q <= resp_data_d;
            timeout_q   <= timeout_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SD_RESP_CRC_EN
    logic [6:0] crc_q, crc_d;
    logic       chk_q;
    logic       crc_fb;

    assign crc_fb  = crc_q[6] ^ crc_din;
    assign crc_bad = chk_q & (crc_q != sr_q[6:0]);

    always_comb begin
        crc_d = crc_q;
        if (cfg_load) begin
            crc_d = '0;
        end else if (crc_en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
            chk_q <= 1'b0;
        end else begin
            crc_q <= crc_d;
            if (cfg_load) begin
                chk_q <= check_crc;
            end
        end
    end
`else
    logic unused_crc;
    assign unused_crc = ^{check_crc, cfg_load, crc_en, crc_din};
    assign crc_bad    = 1'b0;
`endif

    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StDone);
    assign resp_data  = resp_data_q;
    assign timeout    = timeout_q;
    assign crc_err    = crc_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Directed self-checking bench for sd_cmd_resp_rx (CRC expectations follow SD_RESP_CRC_EN).
module tb_sd_cmd_resp_rx;

`ifdef SD_RESP_CRC_EN
    localparam bit CrcOn = 1'b1;
`else
    localparam bit CrcOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sd_clk_rise = 1'b0;
    logic         cmd_in = 1'b1;
    logic         start = 1'b0;
    logic         long_resp = 1'b0;
    logic         check_crc = 1'b0;
    logic         abort = 1'b0;
    logic         busy;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [127:0] resp_data;
    logic         timeout;
    logic         crc_err;
    logic         frame_err;

    int errors = 0;
    int checks = 0;

    logic [39:0]  t1_body;
    logic [135:0] t1_frame;
    logic [135:0] t2_frame;
    logic [119:0] cid;
    logic [119:0] cid_bad;
    logic [6:0]   cid_crc;
    logic [39:0]  r3_body;
    logic [135:0] r3_frame;
    logic [127:0] held;

    sd_cmd_resp_rx #(.TIMEOUT_CLKS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sd_clk_rise(sd_clk_rise),
        .cmd_in     (cmd_in),
        .start      (start),
        .long_resp  (long_resp),
        .check_crc  (check_crc),
        .abort      (abort),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .timeout    (timeout),
        .crc_err    (crc_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] crc7(input logic [127:0] d, input int n);
        logic [6:0] c = 7'd0;
        logic       fb;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line carries the opposite level on the non-strobe cycle.
    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        cmd_in = b;
        sd_clk_rise = 1'b1;
        @(posedge clk); #1;
        sd_clk_rise = 1'b0;
        cmd_in = ~b;
    endtask

    task automatic do_start(input logic lng, input logic chkc);
        @(posedge clk); #1;
        start = 1'b1;
        long_resp = lng;
        check_crc = chkc;
        @(posedge clk); #1;
        start = 1'b0;
        long_resp = 1'b0;
        check_crc = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [135:0] f, input int n);
        for (int i = n - 1; i >= 1; i--) send_bit(f[i]);
        chk({tag, "_pre_valid"}, {127'b0, resp_valid}, 128'd0);
        send_bit(f[0]);
        chk({tag, "_valid_lat"}, {127'b0, resp_valid}, 128'd1);
    endtask

    task automatic check_resp(input string tag, input logic [127:0] d, input logic to,
                              input logic ce, input logic fe);
        chk({tag, "_data"}, resp_data, d);
        chk({tag, "_flags"}, {125'b0, timeout, crc_err, frame_err}, {125'b0, to, ce, fe});
    endtask

    task automatic accept(input string tag);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_idle"}, {126'b0, busy, resp_valid}, 128'd0);
    endtask

    initial begin
        t1_body  = {2'b00, 6'd8, 32'h000001AA};
        t1_frame = {88'b0, t1_body, crc7({88'b0, t1_body}, 40), 1'b1};
        t2_frame = {88'b0, 48'h40_0000_0000_95};
        cid      = 120'h03_5344_5344_3332_8012_3456_7801_2345;
        cid_crc  = crc7({8'b0, cid}, 120);
        cid_bad  = cid ^ (120'd1 << 50);
        r3_body  = {2'b00, 6'h3F, 32'h80FF8000};
        r3_frame = {88'b0, r3_body, 7'h7F, 1'b1};

        // Reset state
        tick(3);
        chk("reset_out", {busy, resp_valid, timeout, crc_err, frame_err, resp_data},
            {5'b0, 128'd0});
        rst_n = 1'b1;
        tick(2);

        // 1: short R7-like frame after 5 idle strobes
        do_start(1'b0, 1'b1);
        chk("t1_busy", {127'b0, busy}, 128'd1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_frame("t1", t1_frame, 48);
        check_resp("t1", 128'h08_0000_01AA, 1'b0, 1'b0, 1'b0);
        accept("t1");

        // 2: host-style frame; ready held high gives a one-cycle valid
        do_start(1'b0, 1'b1);
        resp_ready = 1'b1;
        send_frame("t2", t2_frame, 48);
        check_resp("t2", 128'd0, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk("t2_valid_drop", {126'b0, busy, resp_valid}, 128'd0);
        resp_ready = 1'b0;

        // 3a: timeout after 64 high strobes
        do_start(1'b0, 1'b1);
        for (int i = 0; i < 63; i++) send_bit(1'b1);
        chk("t3_no_tout_63", {126'b0, resp_valid, busy}, 128'd1);
        send_bit(1'b1);
        chk("t3_valid", {127'b0, resp_valid}, 128'd1);
        check_resp("t3", 128'd0, 1'b1, 1'b0, 1'b0);
        accept("t3");

        // 3b: start bit at strobe 63
        do_start(1'b0, 1'b1);
        for (int i = 0; i < 62; i++) send_bit(1'b1);
        send_frame("t3b", t1_frame, 48);
        check_resp("t3b", 128'h08_0000_01AA, 1'b0, 1'b0, 1'b0);
        accept("t3b");

        // 4: long R2, good then corrupted CID bit
        do_start(1'b1, 1'b1);
        send_bit(1'b1);
        send_frame("t4", {2'b00, 6'h3F, cid, cid_crc, 1'b1}, 136);
        check_resp("t4", {1'b0, cid, cid_crc}, 1'b0, 1'b0, 1'b0);
        accept("t4");
        do_start(1'b1, 1'b1);
        send_frame("t4b", {2'b00, 6'h3F, cid_bad, cid_crc, 1'b1}, 136);
        check_resp("t4b", {1'b0, cid_bad, cid_crc}, 1'b0, CrcOn, 1'b0);
        accept("t4b");

        // 5: R3 with fixed 7F CRC field
        do_start(1'b0, 1'b0);
        send_frame("t5", r3_frame, 48);
        check_resp("t5", {90'b0, 6'h3F, 32'h80FF8000}, 1'b0, 1'b0, 1'b0);
        accept("t5");
        do_start(1'b0, 1'b1);
        send_frame("t5b", r3_frame, 48);
        check_resp("t5b", {90'b0, 6'h3F, 32'h80FF8000}, 1'b0,
                   CrcOn && (crc7({88'b0, r3_body}, 40) != 7'h7F), 1'b0);
        accept("t5b");

        // 6a: reset mid-frame at bit 20
        do_start(1'b0, 1'b1);
        for (int i = 47; i >= 28; i--) send_bit(t1_frame[i]);
        rst_n = 1'b0;
        tick(1);
        chk("t6_rst", {126'b0, busy, resp_valid}, 128'd0);
        rst_n = 1'b1;
        tick(1);
        do_start(1'b0, 1'b1);
        send_frame("t6_after_rst", t1_frame, 48);
        check_resp("t6_after_rst", 128'h08_0000_01AA, 1'b0, 1'b0, 1'b0);
        accept("t6_after_rst");

        // 6b: abort mid-frame at bit 20
        do_start(1'b0, 1'b1);
        for (int i = 47; i >= 28; i--) send_bit(t1_frame[i]);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t6_abort", {126'b0, busy, resp_valid}, 128'd0);

        // abort wins over start in the same cycle
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t6_abort_vs_start", {127'b0, busy}, 128'd0);

        // 6c: ready held low for 10 clk with a start pulse during DONE
        do_start(1'b0, 1'b1);
        send_frame("t6c", t2_frame, 48);
        held = resp_data;
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(5);
        chk("t6c_hold_valid", {126'b0, busy, resp_valid}, 128'd3);
        chk("t6c_hold_data", resp_data, held);
        check_resp("t6c", 128'd0, 1'b0, 1'b0, 1'b1);
        accept("t6c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
